// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode encodings, default field widths and
// helpers that locate the sign/exponent/fraction fields inside an operand.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int EW_DEFAULT = 8;
  localparam int MW_DEFAULT = 23;

  // Operand layout is {sign, exp[EW-1:0], frac[MW-1:0]}
  function automatic int signPos(input int ew, input int mw);
    return ew + mw;
  endfunction

  function automatic int expHi(input int ew, input int mw);
    return ew + mw - 1;
  endfunction

  function automatic int expLo(input int mw);
    return mw;
  endfunction

  function automatic int fracHi(input int mw);
    return mw - 1;
  endfunction

endpackage

// File: rtl/exp_mant_compare.sv
// Combinational exponent/fraction comparator: raw exponent difference sign,
// equality, magnitude, and unsigned fraction compare (Y > X).
module exp_mant_compare #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic [EW-1:0] expX,
  input  logic [EW-1:0] expY,
  input  logic [MW-1:0] fracX,
  input  logic [MW-1:0] fracY,
  output logic          DSign,
  output logic          DZF,
  output logic          CMP1,
  output logic [EW-1:0] ExpDiff
);

  logic signed [EW:0] diff;

  // Range of diff is +/-(2^EW-1), so the magnitude always fits in EW bits.
  function automatic logic [EW-1:0] absMag(input logic signed [EW:0] d);
    logic signed [EW:0] neg;
    neg = -d;
    return d[EW] ? neg[EW-1:0] : d[EW-1:0];
  endfunction

  assign diff    = $signed({1'b0, expX}) - $signed({1'b0, expY});
  assign DSign   = ~diff[EW];
  assign DZF     = (diff == '0);
  assign ExpDiff = absMag(diff);
  assign CMP1    = (fracY > fracX);

endmodule

// File: rtl/sign_stage1_compare.sv
// Operand-classification stage ahead of add/sub sign resolution: two-deep
// valid/ready pipeline carrying signs, effective op and exponent/fraction compare.
module sign_stage1_compare
  import fpu_pkg::*;
#(
  parameter int EW = EW_DEFAULT,
  parameter int MW = MW_DEFAULT
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            InValid,
  output logic            InReady,
  input  logic [EW+MW:0]  OperandX,
  input  logic [EW+MW:0]  OperandY,
  input  logic [1:0]      OpCode,
  output logic            OutValid,
  input  logic            OutReady,
  output logic            SignOperandX,
  output logic            SignOperandY,
  output logic            EffOperation,
  output logic            ExclusiveSign,
  output logic            DSign,
  output logic            DZF,
  output logic            CMP1,
  output logic [EW-1:0]   ExpDiff,
  output logic [1:0]      OpCodeOut
);

  localparam int SignBit = signPos(EW, MW);
  localparam int ExpHi   = expHi(EW, MW);
  localparam int ExpLo   = expLo(MW);
  localparam int FracHi  = fracHi(MW);

  logic            readyA, readyB, loadA, loadB;
  logic            dSign_p0, dzf_p0, cmp1_p0;
  logic [EW-1:0]   expDiff_p0;

  logic            vld_p1;
  logic            signX_p1, signY_p1, dSign_p1, dzf_p1, cmp1_p1;
  logic [EW-1:0]   expDiff_p1;
  logic [1:0]      opCode_p1;

  logic            vld_p2;
  logic            signX_p2, signY_p2, dSign_p2, dzf_p2, cmp1_p2;
  logic [EW-1:0]   expDiff_p2;
  logic [1:0]      opCode_p2;

  assign readyB  = ~vld_p2 | OutReady;
  assign readyA  = ~vld_p1 | readyB;
  assign InReady = readyA;
  assign loadA   = InValid & readyA;
  assign loadB   = vld_p1 & readyB;

  // ---- stage p0 -> p1: classify the incoming operand pair
  exp_mant_compare #(.EW(EW), .MW(MW)) uCompare (
    .expX    (OperandX[ExpHi:ExpLo]),
    .expY    (OperandY[ExpHi:ExpLo]),
    .fracX   (OperandX[FracHi:0]),
    .fracY   (OperandY[FracHi:0]),
    .DSign   (dSign_p0),
    .DZF     (dzf_p0),
    .CMP1    (cmp1_p0),
    .ExpDiff (expDiff_p0)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (readyA) vld_p1 <= InValid;
      if (readyB) vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      signX_p1   <= 1'b0;
      signY_p1   <= 1'b0;
      dSign_p1   <= 1'b0;
      dzf_p1     <= 1'b0;
      cmp1_p1    <= 1'b0;
      expDiff_p1 <= '0;
      opCode_p1  <= '0;
    end else if (loadA) begin
      signX_p1   <= OperandX[SignBit];
      signY_p1   <= OperandY[SignBit];
      dSign_p1   <= dSign_p0;
      dzf_p1     <= dzf_p0;
      cmp1_p1    <= cmp1_p0;
      expDiff_p1 <= expDiff_p0;
      opCode_p1  <= OpCode;
    end
  end

  // ---- stage p1 -> p2: output holding bank, frozen while downstream stalls
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      signX_p2   <= 1'b0;
      signY_p2   <= 1'b0;
      dSign_p2   <= 1'b0;
      dzf_p2     <= 1'b0;
      cmp1_p2    <= 1'b0;
      expDiff_p2 <= '0;
      opCode_p2  <= '0;
    end else if (loadB) begin
      signX_p2   <= signX_p1;
      signY_p2   <= signY_p1;
      dSign_p2   <= dSign_p1;
      dzf_p2     <= dzf_p1;
      cmp1_p2    <= cmp1_p1;
      expDiff_p2 <= expDiff_p1;
      opCode_p2  <= opCode_p1;
    end
  end

  assign OutValid      = vld_p2;
  assign SignOperandX  = signX_p2;
  assign SignOperandY  = signY_p2;
  assign EffOperation  = opCode_p2[0];
  assign ExclusiveSign = signX_p2 ^ signY_p2;
  assign DSign         = dSign_p2;
  assign DZF           = dzf_p2;
  assign CMP1          = cmp1_p2;
  assign ExpDiff       = expDiff_p2;
  assign OpCodeOut     = opCode_p2;

endmodule

// File: tb/tb_sign_stage1_compare.sv
// Self-checking bench for sign_stage1_compare: directed vectors with literal
// expectations plus a queue-based reference model checked every cycle.
module tb_sign_stage1_compare;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        InValid, InReady, OutValid, OutReady;
  logic [31:0] OperandX, OperandY;
  logic [1:0]  OpCode;
  logic        SignOperandX, SignOperandY, EffOperation, ExclusiveSign;
  logic        DSign, DZF, CMP1;
  logic [7:0]  ExpDiff;
  logic [1:0]  OpCodeOut;
  logic [16:0] outVec;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [16:0] q[$];
  int          retired = 0;
  int          accepted = 0;
  logic        lastAcc = 1'b0;

  sign_stage1_compare #(.EW(8), .MW(23)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .OperandX(OperandX), .OperandY(OperandY), .OpCode(OpCode),
    .OutValid(OutValid), .OutReady(OutReady),
    .SignOperandX(SignOperandX), .SignOperandY(SignOperandY),
    .EffOperation(EffOperation), .ExclusiveSign(ExclusiveSign),
    .DSign(DSign), .DZF(DZF), .CMP1(CMP1), .ExpDiff(ExpDiff),
    .OpCodeOut(OpCodeOut)
  );

  always #5 Clk = ~Clk;

  assign outVec = {SignOperandX, SignOperandY, EffOperation, ExclusiveSign,
                   DSign, DZF, CMP1, ExpDiff, OpCodeOut};

  // {sx, sy, eff, excl, dsign, dzf, cmp1, expdiff[7:0], op[1:0]}
  function automatic logic [16:0] refModel(input logic [31:0] x, input logic [31:0] y,
                                           input logic [1:0] op);
    int ex, ey, d;
    logic [7:0] mag;
    ex  = int'(x[30:23]);
    ey  = int'(y[30:23]);
    d   = ex - ey;
    mag = 8'(d < 0 ? -d : d);
    return {x[31], y[31], op[0], x[31] ^ y[31], d >= 0, d == 0,
            y[22:0] > x[22:0], mag, op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    nChecks++;
    nFails++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference model: one decision per cycle, taken at the falling edge
  always @(negedge Clk) begin
    if (Rst) begin
      lastAcc = 1'b0;
    end else begin
      check("inReady", 32'(InReady), 32'((q.size() < 2) || OutReady));
      if (q.size() == 0) check("idleOutValid", 32'(OutValid), 32'd0);
      if (q.size() == 2) check("fullOutValid", 32'(OutValid), 32'd1);
      if (OutValid && q.size() > 0) check("stream", 32'(outVec), 32'(q[0]));
      if (OutValid && OutReady && q.size() > 0) begin
        void'(q.pop_front());
        retired++;
      end
      lastAcc = InValid && InReady;
      if (lastAcc) begin
        q.push_back(refModel(OperandX, OperandY, OpCode));
        accepted++;
      end
    end
  end

  // Tasks start and end one time unit after a rising edge.
  task automatic directed(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic [1:0] op, input logic [16:0] exp);
    check({name, "_model"}, 32'(refModel(x, y, op)), 32'(exp));
    OutReady = 1'b1;
    OperandX = x; OperandY = y; OpCode = op; InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    check({name, "_lat1"}, 32'(OutValid), 32'd0);
    @(posedge Clk); #1;
    check({name, "_valid"}, 32'(OutValid), 32'd1);
    check(name, 32'(outVec), 32'(exp));
    @(posedge Clk); #1;
  endtask

  task automatic sendItem(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
    OperandX = x; OperandY = y; OpCode = op; InValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (InReady) begin
        @(posedge Clk); #1;
        InValid = 1'b0;
        return;
      end
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    timeoutFail("sendItem");
  endtask

  task automatic drain();
    OutReady = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge Clk); #1;
    end
    if (q.size() != 0) timeoutFail("drain");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0, sent, cyc;
    logic [16:0] held;
    Rst = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    OperandX = '0; OperandY = '0; OpCode = 2'b00;
    #2;
    check("resetOutValid", 32'(OutValid), 32'd0);
    check("resetOutputs", 32'(outVec), 32'd0);
    @(posedge Clk); @(posedge Clk); #2;
    Rst = 1'b0;
    @(posedge Clk); #1;
    check("postResetInReady", 32'(InReady), 32'd1);

    // Directed vectors: ADD 3.0 + -2.0 shares an exponent; 3.0 + -1.0 differs by one
    directed("add3m2", 32'h40400000, 32'hC0000000, 2'b00,
             {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00});
    directed("add3m1", 32'h40400000, 32'hBF800000, 2'b00,
             {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 2'b00});
    directed("subEqExp", 32'h3F800000, 32'h3FC00000, 2'b01,
             {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 2'b01});
    directed("mulDenInf", 32'h00000001, 32'h7F800000, 2'b10,
             {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 2'b10});
    directed("divInfZero", 32'h7F800000, 32'h00000000, 2'b11,
             {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 2'b11});
    directed("subEqFrac", 32'hC1200000, 32'h41A00000, 2'b01,
             {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 2'b01});

    // Back-to-back stream into a stalled output
    a0 = accepted; r0 = retired;
    OutReady = 1'b0;
    OperandX = 32'h40000000; OperandY = 32'h3F000000; OpCode = 2'b00; InValid = 1'b1;
    @(posedge Clk); #1;
    OperandX = 32'hC0800000; OperandY = 32'h40800000; OpCode = 2'b01;
    @(posedge Clk); #1;
    held = outVec;
    check("stallFirstOut", 32'(held), 32'(refModel(32'h40000000, 32'h3F000000, 2'b00)));
    OperandX = 32'h41000000; OperandY = 32'h42000000; OpCode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("stallInReady", 32'(InReady), 32'd0);
      check("stallHold", 32'(outVec), 32'(held));
      @(posedge Clk); #1;
    end
    OutReady = 1'b1;
    sendItem(32'h41000000, 32'h42000000, 2'b10);
    sendItem(32'h00400000, 32'h80200000, 2'b11);
    drain();
    check("stallAccepted", 32'(accepted - a0), 32'd4);
    check("stallRetired", 32'(retired - r0), 32'd4);

    // Full-rate burst: one item per clock with OutReady held high
    r0 = retired;
    OutReady = 1'b1;
    for (int k = 0; k < 20; k++) begin
      OperandX = $urandom; OperandY = $urandom; OpCode = 2'($urandom_range(0, 3));
      InValid = 1'b1;
      @(negedge Clk);
      check("burstInReady", 32'(InReady), 32'd1);
      if (k >= 2) check("burstOutValid", 32'(OutValid), 32'd1);
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("burstRetired", 32'(retired - r0), 32'd20);

    // Random handshake traffic
    a0 = accepted; r0 = retired; sent = 0; cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      if (InValid && lastAcc) sent++;
      if (!InValid || lastAcc) begin
        if (sent < 10000 && $urandom_range(0, 3) != 0) begin
          OperandX = $urandom; OperandY = $urandom; OpCode = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 7) == 0) OperandY[30:23] = OperandX[30:23];
          if ($urandom_range(0, 15) == 0) OperandX[30:23] = 8'hFF;
          if ($urandom_range(0, 15) == 0) OperandY[30:23] = 8'h00;
          InValid = 1'b1;
        end else begin
          InValid = 1'b0;
        end
      end
      OutReady = ($urandom_range(0, 3) != 0);
      @(posedge Clk); #1;
      cyc++;
    end
    InValid = 1'b0;
    if (sent < 10000) timeoutFail("randomSend");
    drain();
    check("randomAccepted", 32'(accepted - a0), 32'd10000);
    check("randomRetired", 32'(retired - r0), 32'd10000);

    // Asynchronous reset with the pipe full
    OutReady = 1'b0;
    sendItem(32'h40400000, 32'h3F800000, 2'b00);
    sendItem(32'hC0400000, 32'hBF800000, 2'b01);
    check("preResetOutValid", 32'(OutValid), 32'd1);
    #2;
    Rst = 1'b1;
    q.delete();
    #1;
    check("asyncRstOutValid", 32'(OutValid), 32'd0);
    check("asyncRstOutputs", 32'(outVec), 32'd0);
    @(posedge Clk); #2;
    Rst = 1'b0;
    @(posedge Clk); #1;
    directed("afterReset", 32'h3F800000, 32'h40400000, 2'b01,
             {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 2'b01});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
